// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-map constants, responder FSM encoding and address decode.
package lc3_pkg;

    localparam logic [15:0] ADDR_KBSR     = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR     = 16'hFE02;
    localparam logic [15:0] ADDR_DSR      = 16'hFE04;
    localparam logic [15:0] ADDR_DDR      = 16'hFE06;
    localparam logic [15:0] ADDR_UNMAPPED = 16'hFE08;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RGN_RAM  = 3'd0,
        RGN_KBSR = 3'd1,
        RGN_KBDR = 3'd2,
        RGN_DSR  = 3'd3,
        RGN_DDR  = 3'd4,
        RGN_NONE = 3'd5
    } region_t;

    // Odd addresses inside the register window fall through to RAM.
    function automatic region_t decode_addr(input logic [15:0] addr);
        region_t rgn;
        rgn = RGN_RAM;
        if (addr == ADDR_KBSR)
            rgn = RGN_KBSR;
        else if (addr == ADDR_KBDR)
            rgn = RGN_KBDR;
        else if (addr == ADDR_DSR)
            rgn = RGN_DSR;
        else if (addr == ADDR_DDR)
            rgn = RGN_DDR;
        else if (addr >= ADDR_UNMAPPED)
            rgn = RGN_NONE;
        return rgn;
    endfunction

endpackage

// File: rtl/lc3_ram.sv
// Single-port synchronous RAM with registered read (read-first on collision).
module lc3_ram #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: wait-stated RAM plus keyboard/display MMIO registers
// behind a request/ready handshake.
module lc3_mem_responder
    import lc3_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int RAM_AW      = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready
);

    localparam int WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_t             state;
    logic [3:0]         wait_cnt;
    logic               we_reg;
    logic [RAM_AW-1:0]  addr_reg;
    logic [15:0]        wdata_reg;
    region_t            rgn_reg;
    logic               kbd_full;
    logic [7:0]         kbd_buf;

    region_t            req_rgn;
    logic               accept;
    logic               wait_done;
    logic               ram_fire;
    logic               ram_we;
    logic [RAM_AW-1:0]  ram_addr;
    logic [15:0]        ram_wdata;
    logic [15:0]        ram_rdata;
    logic               kbd_load;
    logic               kbd_clear;

    assign req_rgn   = decode_addr(mem_addr);
    assign accept    = (state == IDLE) && mem_req;
    assign wait_done = (state == WAIT) && (wait_cnt == 4'(WAIT_LAST));

    // RAM is touched exactly on the edge that enters RESP, so its registered
    // read word is what RESP presents; with no wait states that is the accept edge.
    assign ram_fire  = (accept && (req_rgn == RGN_RAM) && (WAIT_CYCLES == 0)) || wait_done;
    assign ram_addr  = (state == IDLE) ? mem_addr[RAM_AW-1:0] : addr_reg;
    assign ram_wdata = (state == IDLE) ? mem_wdata : wdata_reg;
    assign ram_we    = ram_fire && ((state == IDLE) ? mem_we : we_reg);

    lc3_ram #(
        .AW (RAM_AW),
        .DW (16)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rgn_reg   <= RGN_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        we_reg    <= mem_we;
                        addr_reg  <= mem_addr[RAM_AW-1:0];
                        wdata_reg <= mem_wdata;
                        rgn_reg   <= req_rgn;
                        wait_cnt  <= '0;
                        if ((req_rgn == RGN_RAM) && (WAIT_CYCLES > 0))
                            state <= WAIT;
                        else
                            state <= RESP;
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        state    <= RESP;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_ready = (state == RESP);

    always_comb begin
        mem_rdata = '0;
        if ((state == RESP) && !we_reg) begin
            case (rgn_reg)
                RGN_RAM:  mem_rdata = ram_rdata;
                RGN_KBSR: mem_rdata = {kbd_full, 15'b0};
                RGN_KBDR: mem_rdata = {8'h00, kbd_buf};
                RGN_DSR:  mem_rdata = {~disp_valid, 15'b0};
                default:  mem_rdata = '0;
            endcase
        end
    end

    // A fresh character arriving on the KBDR-read clear edge takes priority.
    assign kbd_ready = ~kbd_full;
    assign kbd_load  = kbd_valid && !kbd_full;
    assign kbd_clear = (state == RESP) && !we_reg && (rgn_reg == RGN_KBDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kbd_full <= 1'b0;
            kbd_buf  <= '0;
        end else if (kbd_load) begin
            kbd_full <= 1'b1;
            kbd_buf  <= kbd_data;
        end else if (kbd_clear) begin
            kbd_full <= 1'b0;
        end
    end

    // DDR writes land on the accept edge; a write while a character is pending is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else if (accept && mem_we && (req_rgn == RGN_DDR) && !disp_valid) begin
            disp_valid <= 1'b1;
            disp_data  <= mem_wdata[7:0];
        end else if (disp_valid && disp_ready) begin
            disp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Randomized bench for lc3_mem_responder against a transaction-level memory-map model.
module tb_lc3_mem_responder;

    localparam int WAIT_CYCLES = 2;
    localparam int RAM_AW      = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;

    always #5 clk = ~clk;

    lc3_mem_responder #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .RAM_AW      (RAM_AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: the memory map as the CPU sees it.
    logic [15:0] m_ram    [4096];
    bit          m_ram_ok [4096];
    bit          m_kbd_full;
    logic [7:0]  m_kbd_buf;
    bit          m_disp_valid;
    logic [7:0]  m_disp_data;

    task automatic model_reset();
        m_kbd_full   = 0;
        m_kbd_buf    = 8'h00;
        m_disp_valid = 0;
        m_disp_data  = 8'h00;
    endtask

    task automatic check_periph(input string tag);
        chk({tag, "_kbd_ready"}, kbd_ready, !m_kbd_full);
        chk({tag, "_disp_valid"}, disp_valid, m_disp_valid);
        chk({tag, "_disp_data"}, disp_data, m_disp_data);
    endtask

    // Drives one request; optionally offers a keyboard character during the response cycle.
    task automatic bus(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                       input bit kv, input logic [7:0] kch,
                       output logic [15:0] rdata, output int lat, output bit leak);
        leak = 0;
        lat  = 0;
        @(negedge clk);
        mem_req = 1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                mem_req   = 0;
                mem_we    = 1'($urandom);
                mem_addr  = 16'($urandom);
                mem_wdata = 16'($urandom);
            end
            if (!mem_ready && mem_rdata !== 16'h0000) leak = 1;
        end while (!mem_ready && lat < 32);
        rdata = mem_rdata;
        if (kv) begin
            kbd_valid = 1; kbd_data = kch;
        end
        @(posedge clk); #1;
        kbd_valid = 0;
        chk("ready_one_cycle", mem_ready, 1'b0);
    endtask

    task automatic access(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                          input bit kv, input logic [7:0] kch);
        logic [15:0] exp_rd, got_rd;
        int          exp_lat, got_lat;
        bit          leak, check_rd, is_kbdr_rd;
        logic [11:0] idx;
        exp_rd = 16'h0000; exp_lat = 1; check_rd = 1;
        idx = addr[11:0];
        is_kbdr_rd = (addr == 16'hFE02) && !we;
        if (addr == 16'hFE00) begin
            if (!we) exp_rd = {m_kbd_full, 15'b0};
        end else if (addr == 16'hFE02) begin
            if (!we) exp_rd = {8'h00, m_kbd_buf};
        end else if (addr == 16'hFE04) begin
            if (!we) exp_rd = {~m_disp_valid, 15'b0};
        end else if (addr == 16'hFE06) begin
            if (we && !m_disp_valid) begin
                m_disp_valid = 1; m_disp_data = wdata[7:0];
            end
        end else if (addr >= 16'hFE08) begin
            exp_rd = 16'h0000;
        end else begin
            exp_lat = 1 + WAIT_CYCLES;
            if (we) begin
                m_ram[idx] = wdata; m_ram_ok[idx] = 1;
            end else begin
                exp_rd = m_ram[idx];
                check_rd = m_ram_ok[idx];
            end
        end
        bus(we, addr, wdata, kv, kch, got_rd, got_lat, leak);
        if (kv && !m_kbd_full) begin
            m_kbd_full = 1; m_kbd_buf = kch;
        end else if (is_kbdr_rd) begin
            m_kbd_full = 0;
        end
        $display("txn we=%0d addr=%h wdata=%h rdata=%h lat=%0d kv=%0d", we, addr, wdata, got_rd, got_lat, kv);
        chk("latency", got_lat, exp_lat);
        if (check_rd) chk("rdata", got_rd, exp_rd);
        chk("rdata_zero_idle", leak, 1'b0);
        check_periph("post");
    endtask

    task automatic kbd_offer(input logic [7:0] ch);
        @(negedge clk);
        kbd_valid = 1; kbd_data = ch;
        @(posedge clk); #1;
        kbd_valid = 0;
        if (!m_kbd_full) begin
            m_kbd_full = 1; m_kbd_buf = ch;
        end
        $display("txn kbd_offer ch=%h kbd_ready=%0d", ch, kbd_ready);
        chk("kbd_offer_ready", kbd_ready, !m_kbd_full);
    endtask

    task automatic disp_drain();
        @(negedge clk);
        disp_ready = 1;
        @(posedge clk); #1;
        disp_ready = 0;
        m_disp_valid = 0;
        $display("txn disp_drain disp_valid=%0d", disp_valid);
        chk("disp_drain_valid", disp_valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        bit          leak;
        int          n;
        logic [15:0] a;
        reset = 1; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
        kbd_valid = 0; kbd_data = 0; disp_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_mem_rdata", mem_rdata, 16'h0000);
        check_periph("rst");
        @(negedge clk);
        reset = 0;

        // RAM write then read with wait states
        access(1, 16'h3005, 16'h1234, 0, 8'h00);
        access(0, 16'h3005, 16'h0000, 0, 8'h00);

        // Keyboard receive
        kbd_offer(8'h41);
        access(0, 16'hFE00, 16'h0000, 0, 8'h00);
        access(0, 16'hFE02, 16'h0000, 0, 8'h00);
        access(0, 16'hFE00, 16'h0000, 0, 8'h00);

        // Display with sink stalled, then drained
        access(1, 16'hFE06, 16'h0048, 0, 8'h00);
        access(0, 16'hFE04, 16'h0000, 0, 8'h00);
        access(1, 16'hFE06, 16'h0049, 0, 8'h00);
        disp_drain();
        access(0, 16'hFE04, 16'h0000, 0, 8'h00);

        // Character arrives on the KBDR-read clear edge while the buffer is empty
        access(0, 16'hFE02, 16'h0000, 1, 8'h42);
        access(0, 16'hFE02, 16'h0000, 0, 8'h00);

        // Unmapped read/write and MMIO writes that must be ignored
        access(0, 16'hFFF0, 16'h0000, 0, 8'h00);
        access(1, 16'hFFF0, 16'hBEEF, 0, 8'h00);
        access(1, 16'hFE00, 16'hFFFF, 0, 8'h00);
        access(0, 16'h3005, 16'h0000, 0, 8'h00);
        access(0, 16'hF005, 16'h0000, 0, 8'h00);

        // Reset while a RAM read sits in WAIT
        kbd_offer(8'h55);
        access(1, 16'hFE06, 16'h0077, 0, 8'h00);
        @(negedge clk);
        mem_req = 1; mem_we = 0; mem_addr = 16'h3005;
        @(posedge clk); #1;
        mem_req = 0;
        #2 reset = 1;
        #1;
        model_reset();
        chk("rstwait_mem_ready", mem_ready, 1'b0);
        chk("rstwait_mem_rdata", mem_rdata, 16'h0000);
        check_periph("rstwait");
        leak = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (mem_ready !== 1'b0) leak = 1;
        end
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (mem_ready !== 1'b0) leak = 1;
        end
        chk("rstwait_no_ready", leak, 1'b0);
        access(0, 16'h3005, 16'h0000, 0, 8'h00);
        access(0, 16'hFE02, 16'h0000, 0, 8'h00);

        // Randomized mix of RAM, MMIO and unmapped traffic
        for (int t = 0; t < 200; t++) begin
            n = $urandom_range(0, 11);
            if (n <= 5)
                a = {4'($urandom_range(0, 14)), 8'h00, 4'($urandom_range(0, 15))};
            else if (n <= 8)
                a = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
            else if (n == 9)
                a = 16'hFE08 + 16'($urandom_range(0, 16'h01F7));
            else
                a = 16'h0000;
            if (n == 10)
                kbd_offer(8'($urandom));
            else if (n == 11)
                disp_drain();
            else
                access(1'($urandom), a, 16'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_mem_responder.md
LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: extra RAM wait states, range 0..15.
REQ-002 SHALL have parameter RAM_AW, default 12: RAM address width; depth 2^RAM_AW words.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports named as follows:
- clk  in  1  rising-edge clock, single domain.
- reset  in  1  asynchronous, active-high.
REQ-004 SHALL have these CPU-side ports:
- mem_req  in  1  request strobe, sampled in IDLE.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  16  word address.
- mem_wdata  in  16  write data.
- mem_rdata  out  16  read data, valid while mem_ready = 1.
- mem_ready  out  1  one-cycle completion pulse.
REQ-005 SHALL have these keyboard ports:
- kbd_valid  in  1  character offered.
- kbd_data  in  8  character.
- kbd_ready  out  1  1 = buffer empty, character can be accepted.
REQ-006 SHALL have these display ports:
- disp_valid  out  1  character pending.
- disp_data  out  8  character.
- disp_ready  in  1  sink accepts the character.

Function
REQ-007 SHALL decode addresses as follows:
- xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR.
- xFE08..xFFFF unmapped.
- All other addresses RAM, index mem_addr[RAM_AW-1:0] (aliasing permitted).
REQ-008 SHALL use FSM states IDLE, WAIT, RESP.
- IDLE→RESP: mem_req = 1 and MMIO/unmapped address.
- IDLE→WAIT: mem_req = 1, RAM address, WAIT_CYCLES > 0.
- IDLE→RESP: mem_req = 1, RAM address, WAIT_CYCLES = 0.
- WAIT→RESP: after WAIT_CYCLES cycles in WAIT.
- RESP→IDLE: unconditionally.
REQ-009 SHALL register mem_we, mem_addr and mem_wdata at acceptance (IDLE with mem_req = 1); inputs are ignored until return to IDLE.
REQ-010 SHALL raise mem_ready for exactly one cycle in RESP.
- MMIO access accepted at edge k: mem_ready high after edge k+1.
- RAM access accepted at edge k: mem_ready high after edge k+1+WAIT_CYCLES.
REQ-011 SHALL ignore mem_req in WAIT and RESP; back-to-back accesses therefore have a minimum spacing of 2 cycles.
REQ-012 SHALL commit a RAM write at the edge entering RESP; mem_rdata = 0 on write responses.
REQ-013 SHALL hold a RAM read word on mem_rdata during RESP; mem_rdata = 0 whenever mem_ready = 0.
REQ-014 SHALL drive keyboard register reads as follows:
- KBSR reads {kbd_full, 15'b0}.
- KBDR reads {8'h00, kbd_buf}.
- A KBDR read clears kbd_full at the edge leaving RESP.
REQ-015 SHALL drive kbd_ready = ~kbd_full and load kbd_buf and set kbd_full when kbd_valid && kbd_ready.
REQ-016 SHALL, if a kbd_valid handshake coincides with the KBDR-read clear edge, let the load win: kbd_full stays 1 with the new character. This case is only reachable because kbd_ready = 1 in that cycle when the buffer was already empty; otherwise no load occurs.
REQ-017 SHALL read DSR as {~disp_valid, 15'b0}.
REQ-018 SHALL, on a DDR write with disp_valid = 0, latch mem_wdata[7:0] into disp_data and set disp_valid at the edge entering RESP.
REQ-019 SHALL silently drop a DDR write while disp_valid = 1 and still complete it with mem_ready.
REQ-020 SHALL clear disp_valid on disp_valid && disp_ready; disp_data is held stable while disp_valid = 1.
REQ-021 SHALL ignore writes to KBSR, KBDR, DSR and unmapped addresses; reads of DDR and unmapped addresses return x0000; all still complete with mem_ready.

Reset
REQ-022 SHALL, on reset assertion at any time (including mid-access), immediately enter IDLE and drive:
- mem_ready = 0, mem_rdata = 0.
- kbd_full = 0 (kbd_ready = 1), kbd_buf = 0.
- disp_valid = 0, disp_data = 0.
- Wait counter = 0.
REQ-023 SHALL discard an in-flight access on reset with no response; RAM contents are not cleared by reset.

Structure
REQ-024 SHALL take the MMIO address constants (KBSR, KBDR, DSR, DDR) and the FSM state encoding from shared package lc3_pkg.
REQ-025 SHALL instantiate one sub-module, lc3_ram: single-port synchronous RAM (clk, we, addr[RAM_AW-1:0], wdata, rdata).

Verification
REQ-026 SHALL cover RAM write then read with WAIT_CYCLES = 2: write x3005←x1234, then read x3005 → mem_ready 3 cycles after each acceptance, read returns x1234.
REQ-027 SHALL cover keyboard receive: kbd_valid with x41 → kbd_ready = 0; KBSR read = x8000; KBDR read = x0041; KBSR read afterwards = x0000.
REQ-028 SHALL cover display with disp_ready held 0:
- DDR write x0048 → disp_valid = 1, disp_data = x48, DSR read = x0000.
- Second DDR write x0049 is dropped; disp_data stays x48.
- disp_ready = 1 → disp_valid = 0, DSR read = x8000.
REQ-029 SHALL cover a simultaneous event: KBDR read clear edge coinciding with kbd_valid x42 (buffer previously empty) → kbd_full = 1, next KBDR read = x0042.
REQ-030 SHALL cover reset in WAIT: reset during a RAM read → no mem_ready pulse, state IDLE, a subsequent read completes normally.
REQ-031 SHALL cover the unmapped address: read xFFF0 → x0000 with mem_ready after 1 cycle; write xFFF0 has no side effect.
